// File: rtl/inst_loader_pkg.sv
// Shared types and defaults for the instruction loader that fills the
// processor's instruction memory from a byte stream.
package inst_loader_pkg;

    localparam int DEF_NUM_WORDS      = 32;
    localparam int DEF_ADDR_W         = 5;
    localparam int DEF_INST_W         = 32;
    localparam int DEF_BYTES_PER_WORD = 4;

    // Bubble instruction used to pad every address the program does not cover.
    localparam logic [31:0] NOP_INST = 32'h0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        RUN,
        HALT
    } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into one instruction word and reports
// when a word is complete (full, or cut short by the last byte of the stream).
module byte_assembler
    import inst_loader_pkg::*;
#(
    parameter int INST_W         = DEF_INST_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    input  logic              byte_last,
    output logic              word_complete,
    output logic              partial,
    output logic [INST_W-1:0] word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]  idx;
    logic [INST_W-1:0] data;
    logic              last_lane;

    // Upper lanes of data are always zero, so OR-ing the new byte in leaves
    // unfilled bytes of a short final word at zero.
    assign last_lane     = (idx == IDX_W'(BYTES_PER_WORD - 1));
    assign word_complete = accept && (last_lane || byte_last);
    assign partial       = accept && byte_last && !last_lane;
    assign word          = data | (INST_W'(byte_in) << {idx, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            data <= '0;
        end else if (clear) begin
            idx  <= '0;
            data <= '0;
        end else if (accept) begin
            if (word_complete) begin
                idx  <= '0;
                data <= '0;
            end else begin
                idx  <= idx + 1'b1;
                data <= word;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Loads a program byte stream into instruction memory, pads the rest with
// bubbles, then runs the processor until it reports done.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int NUM_WORDS      = DEF_NUM_WORDS,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int INST_W         = DEF_INST_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              proc_run,
    input  logic              proc_done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W:0]   WL_MAX    = (ADDR_W + 1)'(NUM_WORDS);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              start;
    logic              word_complete;
    logic              partial;
    logic [INST_W-1:0] word;
    logic              stream_end;
    logic              final_write_out;

    assign byte_ready      = (state == LOAD);
    assign accept          = byte_valid && byte_ready;
    assign start           = load_start && ((state == IDLE) || (state == HALT));
    assign stream_end      = word_complete && (byte_last || (addr == LAST_ADDR));
    assign final_write_out = imem_we && (imem_waddr == LAST_ADDR);

    byte_assembler #(
        .INST_W         (INST_W),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .clear         (start),
        .accept        (accept),
        .byte_in       (byte_in),
        .byte_last     (byte_last),
        .word_complete (word_complete),
        .partial       (partial),
        .word          (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FILL is entered while the last stream word is being written, so the
    // run handoff is always keyed off the write to the top address.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_start) next_state = LOAD;
            LOAD:    if (stream_end) next_state = FILL;
            FILL:    if (final_write_out) next_state = RUN;
            RUN:     if (proc_done) next_state = HALT;
            HALT:    if (load_start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr         <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            frame_err    <= 1'b0;
            proc_run     <= 1'b0;
        end else begin
            proc_run <= (next_state == RUN);
            imem_we  <= 1'b0;
            if (start) begin
                addr         <= '0;
                words_loaded <= '0;
                frame_err    <= 1'b0;
            end else if (state == LOAD && word_complete) begin
                imem_we    <= 1'b1;
                imem_waddr <= addr;
                imem_wdata <= word;
                if (addr != LAST_ADDR) addr <= addr + 1'b1;
                if (words_loaded != WL_MAX) words_loaded <= words_loaded + 1'b1;
                if (partial) frame_err <= 1'b1;
            end else if (state == FILL && !final_write_out) begin
                imem_we    <= 1'b1;
                imem_waddr <= addr;
                imem_wdata <= INST_W'(NOP_INST);
                if (addr != LAST_ADDR) addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of program loads plus hand-written
// corner sequences, with a write scoreboard fed by a byte-packing model.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;
    logic        proc_done = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        proc_run;
    logic [5:0]  words_loaded;
    logic        frame_err;

    inst_loader dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .proc_run     (proc_run),
        .proc_done    (proc_done),
        .words_loaded (words_loaded),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int nbytes;
        bit use_last;
        int exp_words;
        bit exp_err;
        int exp_accepted;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         write_count = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    vec_t       vecs[7];
    logic [7:0] prog[0:139];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Write monitor: every write must match the next expected entry in order.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            write_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: actual write @%0d data %0h, required no write",
                         imem_waddr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("imem_waddr", 32'(imem_waddr), 32'(mon_e.addr));
                checkOutput("imem_wdata", imem_wdata, mon_e.data);
            end
        end
    end

    // Reference packing: little-endian lanes, zero upper bytes, stream capped
    // at 32 words, remaining addresses padded with bubbles.
    task automatic pushExpected(input int n);
        int   eff;
        int   nw;
        wr_t  e;
        eff = (n > 128) ? 128 : n;
        nw  = (eff + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            e.addr = 5'(w);
            e.data = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < eff) e.data[8*b +: 8] = prog[4*w + b];
            exp_q.push_back(e);
        end
        for (int a = nw; a < 32; a++) begin
            e.addr = 5'(a);
            e.data = 32'h0;
            exp_q.push_back(e);
        end
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        byte_last  = 1'b0;
        checkOutput("byte_ready_on_start", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;
        load_start = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last, output bit acc);
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        acc        = byte_ready;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit use_last, output int accepted);
        bit acc;
        pushExpected(n);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            sendByte(prog[i], use_last && (i == n - 1), acc);
            if (acc) accepted++;
        end
    endtask

    task automatic waitRun(output int cycles);
        cycles = 0;
        while (!proc_run && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("proc_run_reached", 32'(proc_run), 32'd1);
    endtask

    task automatic haltProc();
        proc_done = 1'b1;
        @(posedge clk); #1;
        proc_done = 1'b0;
        checkOutput("proc_run_after_done", 32'(proc_run), 32'd0);
        checkOutput("byte_ready_in_halt", 32'(byte_ready), 32'd0);
    endtask

    initial begin
        int  acc_cnt;
        int  cyc;
        int  wc0;
        int  k;
        bit  acc;

        vecs[0] = '{nbytes: 4,   use_last: 1'b1, exp_words: 1,  exp_err: 1'b0, exp_accepted: 4};
        vecs[1] = '{nbytes: 7,   use_last: 1'b1, exp_words: 2,  exp_err: 1'b1, exp_accepted: 7};
        vecs[2] = '{nbytes: 1,   use_last: 1'b1, exp_words: 1,  exp_err: 1'b1, exp_accepted: 1};
        vecs[3] = '{nbytes: 124, use_last: 1'b1, exp_words: 31, exp_err: 1'b0, exp_accepted: 124};
        vecs[4] = '{nbytes: 125, use_last: 1'b1, exp_words: 32, exp_err: 1'b1, exp_accepted: 125};
        vecs[5] = '{nbytes: 128, use_last: 1'b1, exp_words: 32, exp_err: 1'b0, exp_accepted: 128};
        vecs[6] = '{nbytes: 130, use_last: 1'b0, exp_words: 32, exp_err: 1'b0, exp_accepted: 128};

        // Reset values
        #12;
        checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("rst_imem_waddr", 32'(imem_waddr), 32'd0);
        checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
        checkOutput("rst_proc_run", 32'(proc_run), 32'd0);
        checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // IDLE ignores bytes without load_start
        sendByte(8'h55, 1'b0, acc);
        checkOutput("idle_byte_accepted", 32'(acc), 32'd0);

        // Nominal load, bytes back to back
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h10; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h20; prog[7] = 8'h00;
        wc0 = write_count;
        startLoad();
        applyStimulus(8, 1'b1, acc_cnt);
        checkOutput("nominal_accepted", 32'(acc_cnt), 32'd8);
        waitRun(cyc);
        checkOutput("nominal_run_latency", 32'(cyc), 32'd31);
        checkOutput("nominal_write_count", 32'(write_count - wc0), 32'd32);
        checkOutput("nominal_words_loaded", 32'(words_loaded), 32'd2);
        checkOutput("nominal_frame_err", 32'(frame_err), 32'd0);

        // load_start in RUN is ignored
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("run_ignores_start_proc_run", 32'(proc_run), 32'd1);
            checkOutput("run_ignores_start_ready", 32'(byte_ready), 32'd0);
        end
        haltProc();

        // Partial final word, with a stray byte_last while byte_valid is low
        prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC; prog[3] = 8'hDD; prog[4] = 8'hEE;
        startLoad();
        pushExpected(5);
        acc_cnt = 0;
        sendByte(8'hAA, 1'b0, acc); acc_cnt += int'(acc);
        sendByte(8'hBB, 1'b0, acc); acc_cnt += int'(acc);
        byte_last = 1'b1;
        @(posedge clk); #1;
        byte_last = 1'b0;
        sendByte(8'hCC, 1'b0, acc); acc_cnt += int'(acc);
        sendByte(8'hDD, 1'b0, acc); acc_cnt += int'(acc);
        sendByte(8'hEE, 1'b1, acc); acc_cnt += int'(acc);
        checkOutput("partial_accepted", 32'(acc_cnt), 32'd5);
        waitRun(cyc);
        checkOutput("partial_frame_err", 32'(frame_err), 32'd1);
        checkOutput("partial_words_loaded", 32'(words_loaded), 32'd2);
        haltProc();
        checkOutput("halt_holds_frame_err", 32'(frame_err), 32'd1);

        // Table of loads, each a reload from HALT
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < vecs[v].nbytes; j++) prog[j] = 8'($urandom);
            startLoad();
            checkOutput("reload_words_cleared", 32'(words_loaded), 32'd0);
            checkOutput("reload_err_cleared", 32'(frame_err), 32'd0);
            checkOutput("reload_ready", 32'(byte_ready), 32'd1);
            applyStimulus(vecs[v].nbytes, vecs[v].use_last, acc_cnt);
            checkOutput("vec_accepted", 32'(acc_cnt), 32'(vecs[v].exp_accepted));
            waitRun(cyc);
            checkOutput("vec_words_loaded", 32'(words_loaded), 32'(vecs[v].exp_words));
            checkOutput("vec_frame_err", 32'(frame_err), 32'(vecs[v].exp_err));
            checkOutput("vec_scoreboard_drained", 32'(exp_q.size()), 32'd0);
            haltProc();
        end

        // Asynchronous reset in the middle of FILL
        for (int j = 0; j < 8; j++) prog[j] = 8'($urandom);
        startLoad();
        applyStimulus(8, 1'b1, acc_cnt);
        k = 0;
        while (!(imem_we && imem_waddr == 5'd10) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("fill_reached_addr10", 32'(imem_we && imem_waddr == 5'd10), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_proc_run", 32'(proc_run), 32'd0);
        checkOutput("async_rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("async_rst_byte_ready", 32'(byte_ready), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wc0 = write_count;
        sendByte(8'h11, 1'b1, acc);
        checkOutput("post_rst_byte_accepted", 32'(acc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("post_rst_no_writes", 32'(write_count - wc0), 32'd0);
        checkOutput("post_rst_proc_run", 32'(proc_run), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
